// File: rtl/sr_pkg.sv
// rtl/sr_pkg.sv - shared types and constants for the super-resolution window scheduler
// Contents: controller state enum, 3x3 tap offsets (row-major, tap 4 = centre),
// zero-pixel constant used for padding, and the frame address width helper.
package sr_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_START,
        S_WAIT_SR,
        S_PUSH,
        S_DONE
    } state_t;

    localparam int NUM_TAPS = 9;

    localparam int TAP_DX [NUM_TAPS] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};
    localparam int TAP_DY [NUM_TAPS] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};

    // Wide enough for any realistic pixel; users truncate to PIXEL_WIDTH.
    localparam logic [63:0] ZERO_PIXEL = '0;

    function automatic int calc_addr_w(input int w, input int h);
        return $clog2(w * h);
    endfunction

endpackage

// File: rtl/sr_raster_counter.sv
// rtl/sr_raster_counter.sv - x/y/linear-address raster counter with row wrap
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   clr                 restart at pixel (0,0)
//   adv                 step to the next pixel in raster order
//   x, y, addr          current pixel position and its linear frame address
//   x_nxt, y_nxt, addr_nxt  values the counter will hold after this edge
//   last_col, last_row, last_pixel  current pixel sits on the right edge / bottom edge / both
module sr_raster_counter
    import sr_pkg::*;
#(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    localparam int ADDR_W = calc_addr_w(WIDTH, HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              adv,
    output logic [15:0]       x,
    output logic [15:0]       y,
    output logic [ADDR_W-1:0] addr,
    output logic [15:0]       x_nxt,
    output logic [15:0]       y_nxt,
    output logic [ADDR_W-1:0] addr_nxt,
    output logic              last_col,
    output logic              last_row,
    output logic              last_pixel
);

    assign last_col   = (x == 16'(WIDTH - 1));
    assign last_row   = (y == 16'(HEIGHT - 1));
    assign last_pixel = last_col && last_row;

    // The linear address is stepped alongside x/y so no multiply is needed.
    always_comb begin
        x_nxt    = x;
        y_nxt    = y;
        addr_nxt = addr;
        if (clr) begin
            x_nxt    = '0;
            y_nxt    = '0;
            addr_nxt = '0;
        end else if (adv) begin
            addr_nxt = last_pixel ? '0 : addr + ADDR_W'(1);
            if (last_col) begin
                x_nxt = '0;
                y_nxt = last_row ? '0 : y + 16'd1;
            end else begin
                x_nxt = x + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else begin
            x    <= x_nxt;
            y    <= y_nxt;
            addr <= addr_nxt;
        end
    end

endmodule

// File: rtl/sr_window_scheduler.sv
// rtl/sr_window_scheduler.sv - per-frame 3x3 window fetch and super-resolution core sequencer
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   frame_ready                   pulse: frame buffer complete, start a frame
//   bram_addr / bram_dout         frame-buffer read port (data one cycle after address)
//   sr_start, sr_x, sr_y          core start pulse and pixel position
//   sr_neighborhood               9 taps, tap k at bits [k*PIXEL_WIDTH +: PIXEL_WIDTH]
//   sr_done, sr_pixel             core result handshake
//   fifo_count                    output FIFO fill level
//   fifo_write, fifo_data         output FIFO push
//   busy, frame_done              frame in progress / final pixel pushed
//   err                           sticky: [0] frame_ready while busy, [1] core timeout
module sr_window_scheduler
    import sr_pkg::*;
#(
    parameter int WIDTH       = 320,
    parameter int HEIGHT      = 240,
    parameter int PIXEL_WIDTH = 24,
    parameter int FIFO_LIMIT  = 1000,
    parameter int SR_TIMEOUT  = 4096,
    localparam int ADDR_W     = calc_addr_w(WIDTH, HEIGHT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_ready,
    output logic [ADDR_W-1:0]        bram_addr,
    input  logic [PIXEL_WIDTH-1:0]   bram_dout,
    output logic                     sr_start,
    output logic [15:0]              sr_x,
    output logic [15:0]              sr_y,
    output logic [9*PIXEL_WIDTH-1:0] sr_neighborhood,
    input  logic                     sr_done,
    input  logic [PIXEL_WIDTH-1:0]   sr_pixel,
    input  logic [9:0]               fifo_count,
    output logic                     fifo_write,
    output logic [PIXEL_WIDTH-1:0]   fifo_data,
    output logic                     busy,
    output logic                     frame_done,
    output logic [1:0]               err
);

    state_t            state;
    logic [3:0]        fetch_k;
    logic [31:0]       wait_cnt;

    logic [15:0]       cnt_x, cnt_y, nxt_x, nxt_y;
    logic [ADDR_W-1:0] cnt_addr, nxt_addr;
    logic              last_col, last_row, last_pixel;

    logic              accept;
    logic              push_ok;
    int                cap_idx;
    logic              cap_ok;

    function automatic logic tap_ok(input int k, input logic at_l, input logic at_r,
                                    input logic at_t, input logic at_b);
        logic ok;
        ok = 1'b1;
        if (TAP_DX[k] < 0 && at_l) ok = 1'b0;
        if (TAP_DX[k] > 0 && at_r) ok = 1'b0;
        if (TAP_DY[k] < 0 && at_t) ok = 1'b0;
        if (TAP_DY[k] > 0 && at_b) ok = 1'b0;
        return ok;
    endfunction

    // Out-of-frame taps re-read the centre; the captured value is zeroed anyway.
    // Negative offsets wrap modulo 2^ADDR_W, which is exact for in-frame taps.
    function automatic logic [ADDR_W-1:0] tap_addr(input int k, input logic ok,
                                                   input logic [ADDR_W-1:0] ca);
        if (!ok) return ca;
        return ca + ADDR_W'(TAP_DY[k] * WIDTH + TAP_DX[k]);
    endfunction

    assign accept  = (state == S_IDLE) && frame_ready;
    assign push_ok = (state == S_PUSH) && (int'(fifo_count) <= FIFO_LIMIT);

    // Combinational so the push decision uses this cycle's fill level.
    assign fifo_write = push_ok && !rst;

    assign sr_x = cnt_x;
    assign sr_y = cnt_y;

    sr_raster_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_raster (
        .clk        (clk),
        .rst        (rst),
        .clr        (accept),
        .adv        (push_ok),
        .x          (cnt_x),
        .y          (cnt_y),
        .addr       (cnt_addr),
        .x_nxt      (nxt_x),
        .y_nxt      (nxt_y),
        .addr_nxt   (nxt_addr),
        .last_col   (last_col),
        .last_row   (last_row),
        .last_pixel (last_pixel)
    );

    // Data on bram_dout belongs to the tap issued in the previous cycle.
    always_comb begin
        cap_idx = 0;
        if (state == S_DRAIN) cap_idx = 8;
        else if (fetch_k != 4'd0) cap_idx = int'(fetch_k) - 1;
        cap_ok = tap_ok(cap_idx, cnt_x == 16'd0, last_col, cnt_y == 16'd0, last_row);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            fetch_k         <= '0;
            wait_cnt        <= '0;
            bram_addr       <= '0;
            sr_neighborhood <= '0;
            sr_start        <= 1'b0;
            fifo_data       <= '0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            err             <= '0;
        end else begin
            sr_start   <= 1'b0;
            frame_done <= 1'b0;
            if (frame_ready && state != S_IDLE) err[0] <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (frame_ready) begin
                        state     <= S_FETCH;
                        busy      <= 1'b1;
                        fetch_k   <= '0;
                        bram_addr <= tap_addr(0, tap_ok(0, nxt_x == 16'd0, nxt_x == 16'(WIDTH - 1),
                                                        nxt_y == 16'd0, nxt_y == 16'(HEIGHT - 1)),
                                              nxt_addr);
                    end
                end
                S_FETCH: begin
                    if (fetch_k != 4'd0)
                        sr_neighborhood[cap_idx*PIXEL_WIDTH +: PIXEL_WIDTH] <=
                            cap_ok ? bram_dout : PIXEL_WIDTH'(ZERO_PIXEL);
                    if (fetch_k == 4'd8) begin
                        state <= S_DRAIN;
                    end else begin
                        fetch_k   <= fetch_k + 4'd1;
                        bram_addr <= tap_addr(int'(fetch_k) + 1,
                                              tap_ok(int'(fetch_k) + 1, cnt_x == 16'd0, last_col,
                                                     cnt_y == 16'd0, last_row),
                                              cnt_addr);
                    end
                end
                S_DRAIN: begin
                    sr_neighborhood[cap_idx*PIXEL_WIDTH +: PIXEL_WIDTH] <=
                        cap_ok ? bram_dout : PIXEL_WIDTH'(ZERO_PIXEL);
                    state    <= S_START;
                    sr_start <= 1'b1;
                end
                S_START: begin
                    state    <= S_WAIT_SR;
                    wait_cnt <= '0;
                end
                S_WAIT_SR: begin
                    if (sr_done) begin
                        fifo_data <= sr_pixel;
                        state     <= S_PUSH;
                    end else if (wait_cnt == 32'(SR_TIMEOUT - 1)) begin
                        fifo_data <= '0;
                        err[1]    <= 1'b1;
                        state     <= S_PUSH;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                S_PUSH: begin
                    if (push_ok) begin
                        if (last_pixel) begin
                            state      <= S_DONE;
                            frame_done <= 1'b1;
                        end else begin
                            state     <= S_FETCH;
                            fetch_k   <= '0;
                            bram_addr <= tap_addr(0, tap_ok(0, nxt_x == 16'd0, nxt_x == 16'(WIDTH - 1),
                                                            nxt_y == 16'd0, nxt_y == 16'(HEIGHT - 1)),
                                                  nxt_addr);
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
